// File: rtl/cmp_share_pkg.sv
// Shared types and helpers for the time-shared comparator scheduler.
package cmp_share_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StCmp  = 2'd1,
      StResp = 2'd2
   } state_e;

   localparam int unsigned DefaultNumReq = 4;
   localparam int unsigned DefaultIdW    = $clog2(DefaultNumReq);

   // Width of a requester index; never narrower than one bit.
   function automatic int unsigned id_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/cmp_core.sv
// Combinational unsigned magnitude comparator.
module cmp_core #(
   parameter int unsigned WIDTH = 3
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             less,
   output logic             equal,
   output logic             greater
);

   always_comb begin
      less    = (a < b);
      equal   = (a == b);
      greater = (a > b);
   end

endmodule

// File: rtl/cmp_share_sched.sv
// Round-robin scheduler sharing one comparator among NUM_REQ requesters,
// returning each result on a valid/ready port tagged with the requester id.
module cmp_share_sched
   import cmp_share_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned WIDTH   = 3,
   localparam int unsigned IdW    = id_width(NUM_REQ)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_REQ-1:0]       req,
   input  logic [NUM_REQ*WIDTH-1:0] a_flat,
   input  logic [NUM_REQ*WIDTH-1:0] b_flat,
   output logic [NUM_REQ-1:0]       ack,
   output logic                     resp_valid,
   input  logic                     resp_ready,
   output logic [IdW-1:0]           resp_id,
   output logic                     less,
   output logic                     equal,
   output logic                     greater,
   output logic                     busy
);

   state_e           state_q, state_d;
   logic [IdW-1:0]   ptr_q, ptr_d;
   logic [WIDTH-1:0] op_a_q, op_a_d;
   logic [WIDTH-1:0] op_b_q, op_b_d;
   logic [IdW-1:0]   resp_id_q, resp_id_d;
   logic             valid_q, valid_d;
   logic             less_q, less_d;
   logic             equal_q, equal_d;
   logic             greater_q, greater_d;

   logic             found;
   logic [IdW-1:0]   grant_idx;
   logic [WIDTH-1:0] sel_a, sel_b;
   logic             core_less, core_equal, core_greater;
   int unsigned      idx;

   // First set request at or above ptr, wrapping past NUM_REQ-1.
   always_comb begin
      found     = 1'b0;
      grant_idx = '0;
      sel_a     = '0;
      sel_b     = '0;
      idx       = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = (32'(ptr_q) + 32'(k)) % NUM_REQ;
         if (!found && req[idx]) begin
            found     = 1'b1;
            grant_idx = IdW'(idx);
            sel_a     = a_flat[idx*WIDTH +: WIDTH];
            sel_b     = b_flat[idx*WIDTH +: WIDTH];
         end
      end
   end

   cmp_core #(
      .WIDTH(WIDTH)
   ) u_cmp_core (
      .a      (op_a_q),
      .b      (op_b_q),
      .less   (core_less),
      .equal  (core_equal),
      .greater(core_greater)
   );

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      op_a_d    = op_a_q;
      op_b_d    = op_b_q;
      resp_id_d = resp_id_q;
      valid_d   = valid_q;
      less_d    = less_q;
      equal_d   = equal_q;
      greater_d = greater_q;
      unique case (state_q)
         StIdle: begin
            if (found) begin
               op_a_d    = sel_a;
               op_b_d    = sel_b;
               resp_id_d = grant_idx;
               ptr_d     = (grant_idx == IdW'(NUM_REQ - 1)) ? '0 : grant_idx + IdW'(1);
               state_d   = StCmp;
            end
         end
         StCmp: begin
            less_d    = core_less;
            equal_d   = core_equal;
            greater_d = core_greater;
            valid_d   = 1'b1;
            state_d   = StResp;
         end
         StResp: begin
            if (resp_ready) begin
               valid_d = 1'b0;
               state_d = StIdle;
            end
         end
         default: begin
            valid_d = 1'b0;
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         ptr_q     <= '0;
         op_a_q    <= '0;
         op_b_q    <= '0;
         resp_id_q <= '0;
         valid_q   <= 1'b0;
         less_q    <= 1'b0;
         equal_q   <= 1'b0;
         greater_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         op_a_q    <= op_a_d;
         op_b_q    <= op_b_d;
         resp_id_q <= resp_id_d;
         valid_q   <= valid_d;
         less_q    <= less_d;
         equal_q   <= equal_d;
         greater_q <= greater_d;
      end
   end

   always_comb begin
      ack = '0;
      if (valid_q && resp_ready) begin
         ack[resp_id_q] = 1'b1;
      end
   end

   assign resp_valid = valid_q;
   assign resp_id    = resp_id_q;
   assign less       = less_q;
   assign equal      = equal_q;
   assign greater    = greater_q;
   assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_cmp_share_sched.sv
// Directed bench for cmp_share_sched: vector table plus multi-cycle sequences.
module tb_cmp_share_sched;

   localparam int unsigned NumReq = 4;
   localparam int unsigned Width  = 3;

   logic                    clk = 1'b0;
   logic                    rst_n;
   logic [NumReq-1:0]       req;
   logic [NumReq*Width-1:0] a_flat;
   logic [NumReq*Width-1:0] b_flat;
   logic [NumReq-1:0]       ack;
   logic                    resp_valid;
   logic                    resp_ready;
   logic [1:0]              resp_id;
   logic                    less, equal, greater;
   logic                    busy;

   int n_checks = 0;
   int n_fail   = 0;

   cmp_share_sched #(
      .NUM_REQ(NumReq),
      .WIDTH  (Width)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .a_flat    (a_flat),
      .b_flat    (b_flat),
      .ack       (ack),
      .resp_valid(resp_valid),
      .resp_ready(resp_ready),
      .resp_id   (resp_id),
      .less      (less),
      .equal     (equal),
      .greater   (greater),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         idx;
      logic [2:0] a;
      logic [2:0] b;
      logic [2:0] flags;  // {less, equal, greater}
   } vec_t;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(input string name, output int cyc);
      cyc = 0;
      while (!resp_valid && cyc < 10) begin
         step();
         cyc++;
      end
      if (!resp_valid) check({name, "_timeout"}, 32'(resp_valid), 32'd1);
   endtask

   task automatic do_txn(input vec_t v);
      int cyc;
      a_flat[v.idx*Width +: Width] = v.a;
      b_flat[v.idx*Width +: Width] = v.b;
      resp_ready = 1'b1;
      req        = '0;
      req[v.idx] = 1'b1;
      wait_valid("txn", cyc);
      check("txn_latency", 32'(cyc), 32'd2);
      check("txn_id", 32'(resp_id), 32'(v.idx));
      check("txn_flags", 32'({less, equal, greater}), 32'(v.flags));
      check("txn_onehot", 32'($countones({less, equal, greater})), 32'd1);
      check("txn_ack", 32'(ack), 32'(4'b0001 << v.idx));
      req[v.idx] = 1'b0;
      step();
      check("txn_valid_drop", 32'(resp_valid), 32'd0);
      check("txn_busy_drop", 32'(busy), 32'd0);
      check("txn_ack_drop", 32'(ack), 32'd0);
      check("txn_flags_hold", 32'({less, equal, greater}), 32'(v.flags));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t vecs[6];
      int   cyc;
      vecs[0] = '{idx: 1, a: 3'd5, b: 3'd3, flags: 3'b001};
      vecs[1] = '{idx: 0, a: 3'd0, b: 3'd0, flags: 3'b010};
      vecs[2] = '{idx: 0, a: 3'd7, b: 3'd0, flags: 3'b001};
      vecs[3] = '{idx: 0, a: 3'd0, b: 3'd7, flags: 3'b100};
      vecs[4] = '{idx: 3, a: 3'd4, b: 3'd4, flags: 3'b010};
      vecs[5] = '{idx: 2, a: 3'd1, b: 3'd6, flags: 3'b100};

      rst_n      = 1'b0;
      req        = '0;
      resp_ready = 1'b0;
      a_flat     = '0;
      b_flat     = '0;
      #12;
      check("rst_valid", 32'(resp_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_id", 32'(resp_id), 32'd0);
      check("rst_flags", 32'({less, equal, greater}), 32'd0);
      check("rst_ack", 32'(ack), 32'd0);
      rst_n = 1'b1;
      step();

      foreach (vecs[i]) do_txn(vecs[i]);

      // Reset while a response is pending: everything clears at once.
      resp_ready = 1'b0;
      a_flat[2*Width +: Width] = 3'd1;
      b_flat[2*Width +: Width] = 3'd6;
      req = 4'b0100;
      wait_valid("rstmid", cyc);
      check("rstmid_pre_valid", 32'(resp_valid), 32'd1);
      req = '0;
      #2;
      resp_ready = 1'b1;
      rst_n      = 1'b0;
      #1;
      check("rstmid_valid", 32'(resp_valid), 32'd0);
      check("rstmid_flags", 32'({less, equal, greater}), 32'd0);
      check("rstmid_busy", 32'(busy), 32'd0);
      check("rstmid_ack", 32'(ack), 32'd0);
      #2;
      rst_n = 1'b1;
      step();

      // Round-robin with all requesting; ptr must restart at 0 after reset.
      req = 4'b1111;
      for (int t = 0; t < 6; t++) begin
         wait_valid("rr", cyc);
         check("rr_id", 32'(resp_id), 32'(t % 4));
         check("rr_ack", 32'(ack), 32'(4'b0001 << (t % 4)));
         req[t % 4] = 1'b0;
         if (t == 5) req = '0;
         step();
         if (t != 5) req[t % 4] = 1'b1;
      end
      check("rr_idle", 32'(busy), 32'd0);

      // Backpressure with other requesters waiting.
      resp_ready = 1'b0;
      a_flat[0 +: Width] = 3'd6;
      b_flat[0 +: Width] = 3'd2;
      req = 4'b0001;
      wait_valid("bp", cyc);
      req = 4'b1111;
      a_flat[0 +: Width] = 3'd1;
      for (int i = 0; i < 5; i++) begin
         check("bp_valid", 32'(resp_valid), 32'd1);
         check("bp_id", 32'(resp_id), 32'd0);
         check("bp_flags", 32'({less, equal, greater}), 32'b001);
         check("bp_ack", 32'(ack), 32'd0);
         step();
      end
      resp_ready = 1'b1;
      #1;
      check("bp_ack_rel", 32'(ack), 32'b0001);
      req = '0;
      step();
      check("bp_valid_drop", 32'(resp_valid), 32'd0);
      check("bp_busy_drop", 32'(busy), 32'd0);
      check("bp_ack_drop", 32'(ack), 32'd0);

      // Operand change after the grant edge must not affect the result.
      a_flat[2*Width +: Width] = 3'd2;
      b_flat[2*Width +: Width] = 3'd6;
      req = 4'b0100;
      step();
      check("opchg_busy", 32'(busy), 32'd1);
      a_flat[2*Width +: Width] = 3'd7;
      step();
      check("opchg_valid", 32'(resp_valid), 32'd1);
      check("opchg_id", 32'(resp_id), 32'd2);
      check("opchg_flags", 32'({less, equal, greater}), 32'b100);
      req = '0;
      step();
      check("opchg_idle", 32'(busy), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/cmp_share_sched.md
Name: cmp_share_sched

Overview:
Time-shares one unsigned magnitude comparator (less/equal/greater) among NUM_REQ requesters. Round-robin arbitration picks one requester and latches its operand pair. The comparison result is presented on a valid/ready response port, tagged with the requester id. The block sits between the per-channel compare clients and the single comparator datapath.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
WIDTH, 3, operand width in bits (unsigned)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
req  in  NUM_REQ  per-requester compare request, level, held until ack
a_flat  in  NUM_REQ*WIDTH  operand A of requester i at bits [i*WIDTH +: WIDTH]
b_flat  in  NUM_REQ*WIDTH  operand B of requester i, same packing
ack  out  NUM_REQ  one-hot, combinational: resp_valid & resp_ready at bit resp_id
resp_valid  out  1  result valid
resp_ready  in  1  consumer accepts result
resp_id  out  clog2(NUM_REQ)  index of requester owning the result
less  out  1  A < B
equal  out  1  A == B
greater  out  1  A > B
busy  out  1  high in any state other than IDLE

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values: state IDLE, rr pointer 0, resp_valid 0, resp_id 0, less/equal/greater 0, busy 0, operand regs 0.
- Reset has immediate effect and aborts any transaction in flight; no ack is issued for it.
- FSM has three states: IDLE, CMP, RESP.
- IDLE: if any req bit is high, grant the first set bit searching from pointer ptr upward, with wrap.
  - Latch that requester's A and B into op regs and its index into resp_id.
  - Set ptr = (grant+1) mod NUM_REQ.
  - Go to CMP.
  - With no req, stay in IDLE and hold ptr.
- CMP: exactly one cycle.
  - Register the comparator result from the latched operands into less/equal/greater.
  - Set resp_valid=1 and go to RESP.
- RESP: hold resp_valid, resp_id, less/equal/greater stable until resp_ready=1.
  - On the handshake edge, clear resp_valid and go to IDLE.
- Latency: grant edge to resp_valid = 2 clocks. Minimum per-transaction time is 3 clocks when resp_ready is held high.
- Operands are sampled only at the grant edge. Later changes to a_flat/b_flat do not affect the result.
- If req drops after grant, the transaction still completes and ack still pulses.
- ack is asserted only during the handshake cycle, so the requester must deassert req at that edge.
  - If req stays high, it is simply re-arbitrated under round-robin rules; no starvation results.
- While resp_valid=1, exactly one of less/equal/greater is high.
  - After the handshake the flags hold their last value; only reset clears them.
- Comparison is unsigned over WIDTH bits. 0 vs 0 gives equal. (2^WIDTH-1) vs 0 gives greater.
- Requests arriving in CMP or RESP are not granted until the next IDLE cycle.
- ptr wraps from NUM_REQ-1 to 0.

Decomposition:
- Package cmp_share_pkg holds:
  - state enum {IDLE, CMP, RESP} as a 2-bit localparam set;
  - an id-width constant derived from clog2(NUM_REQ).
- One sub-module: cmp_core.
  - Purely combinational, WIDTH-parameterised unsigned less/equal/greater.
  - The scheduler registers its outputs in CMP.
- The round-robin search stays inline.

Test Plan:
- Reset mid-RESP: assert rst_n=0 while resp_valid=1 -> resp_valid, flags, busy, ack all 0 immediately; after release, ptr=0 and state IDLE.
- Single requester, resp_ready=1: req=4'b0010, A1=5, B1=3 -> resp_valid 2 clocks after grant, greater=1, resp_id=1, ack=4'b0010 for one cycle, busy drops the next cycle.
- Equal and extremes: sequential transactions on req0 with (0,0), (7,0), (0,7) -> equal, greater, less respectively, exactly one flag high each.
- Round-robin fairness: req=4'b1111 held, each requester drops req on its ack and re-raises it one cycle later -> grant order 0,1,2,3,0,1 and each resp_id matches.
- Backpressure: resp_ready=0 for 5 cycles after resp_valid -> outputs stable, ack=0, no new grant. Raise resp_ready -> single ack, return to IDLE.
- Operand change after grant: req2 with A2=2, B2=6; change A2 to 7 the cycle after grant -> result still less=1.
